// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline hazard signals between datapath and hazard controller
// master: pipeline datapath side; slave: hazard controller.
interface hazard_controller_if;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        ResultSrcE0, RegWriteM, RegWriteW, PCSrcE;
   logic        MemReqM, MemAck, CntClr;
   logic        StallF, StallD, StallE, StallM;
   logic        FlushD, FlushE, FlushW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [15:0] StallCycles, FlushCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAck, CntClr,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  ForwardAE, ForwardBE, StallCycles, FlushCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAck, CntClr,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output ForwardAE, ForwardBE, StallCycles, FlushCount
   );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, load-use, branch and memory-wait hazard control
// Priority: memory stall > branch flush > load-use stall.
module hazard_controller (
   input logic          clk,
   input logic          rst_n,
   hazard_controller_if.slave hz
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t      state, state_nxt;
   logic        memstall, lwraw, lwstall;
   logic        stall_f, stall_d, stall_e, stall_m;
   logic        flush_d, flush_e, flush_w;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt, flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (hz.MemReqM && !hz.MemAck) state_nxt = MEM_WAIT;
         MEM_WAIT: if (hz.MemAck) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)      fwd_a = 2'b10;
      else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E) fwd_a = 2'b01;
      if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)      fwd_b = 2'b10;
      else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E) fwd_b = 2'b01;

      memstall = hz.MemReqM && !hz.MemAck;
      lwraw    = hz.ResultSrcE0 && hz.RdE != 5'd0 &&
                 (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
      // Load-use only counts as the active cause when nothing outranks it.
      lwstall  = lwraw && !memstall && !hz.PCSrcE;

      stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
      flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
      if (memstall) begin
         stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (hz.PCSrcE) begin
         flush_d = 1'b1; flush_e = 1'b1;
      end else if (lwraw) begin
         stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
      end

      if (!rst_n) begin
         stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
         flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
         fwd_a   = 2'b00; fwd_b = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else if (hz.CntClr) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (stall_f && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (flush_e && !lwstall && flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

   assign hz.StallF      = stall_f;
   assign hz.StallD      = stall_d;
   assign hz.StallE      = stall_e;
   assign hz.StallM      = stall_m;
   assign hz.FlushD      = flush_d;
   assign hz.FlushE      = flush_e;
   assign hz.FlushW      = flush_w;
   assign hz.ForwardAE   = fwd_a;
   assign hz.ForwardBE   = fwd_b;
   assign hz.StallCycles = stall_cnt;
   assign hz.FlushCount  = flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller
// Output vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}.
module tb_hazard_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_controller_if hz ();
   hazard_controller dut (.clk(clk), .rst_n(rst_n), .hz(hz));

   typedef struct {
      string      tag;
      logic [10:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [10:0] NONE  = 11'b0000000_00_00;
   localparam logic [10:0] MEMST = 11'b1111001_00_00;
   localparam logic [10:0] LWST  = 11'b1100010_00_00;
   localparam logic [10:0] BRFL  = 11'b0000110_00_00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] outs();
      return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
              hz.FlushD, hz.FlushE, hz.FlushW, hz.ForwardAE, hz.ForwardBE};
   endfunction

   task automatic idle();
      hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
      hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
      hz.ResultSrcE0 = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
      hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemAck = 1'b0; hz.CntClr = 1'b0;
   endtask

   // Inputs already driven; push the expectation, compare mid-cycle, advance one edge.
   task automatic step(input string tag, input logic [10:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      check(e.tag, {21'd0, outs()}, {21'd0, e.exp});
      @(posedge clk);
      #1;
   endtask

   task automatic counters(input string tag, input logic [15:0] sc, input logic [15:0] fc);
      check({tag, "_stallcycles"}, {16'd0, hz.StallCycles}, {16'd0, sc});
      check({tag, "_flushcount"},  {16'd0, hz.FlushCount},  {16'd0, fc});
   endtask

   initial begin
      idle();
      // Reset with inputs that would otherwise forward and mem-stall
      hz.RegWriteM = 1'b1; hz.RdM = 5'd3; hz.Rs1E = 5'd3;
      hz.MemReqM = 1'b1;
      #2;
      check("reset_outputs", {21'd0, outs()}, 32'd0);
      counters("reset", 16'd0, 16'd0);
      check("reset_state", {31'd0, dut.state}, 32'd0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Forwarding: MEM priority, then WB, then register file
      hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5;
      hz.Rs1E = 5'd5; hz.Rs2E = 5'd0;
      step("fwd_mem_prio", 11'b0000000_10_00);
      hz.RdM = 5'd0;
      step("fwd_rdm_zero", 11'b0000000_01_00);
      hz.RegWriteM = 1'b0; hz.RdM = 5'd5; hz.Rs2E = 5'd5;
      step("fwd_wb_both", 11'b0000000_01_01);
      hz.RegWriteM = 1'b1; hz.RdM = 5'd9; hz.Rs2E = 5'd9; hz.RdW = 5'd0;
      step("fwd_b_mem", 11'b0000000_00_10);
      idle();

      // Load-use
      hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      step("loaduse", LWST);
      counters("loaduse", 16'd1, 16'd0);
      hz.RdE = 5'd0; hz.Rs2D = 5'd0;
      step("load_rd0", NONE);
      idle();

      // Memory wait: 3 cycles without ack, then ack
      hz.MemReqM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("memwait", MEMST);
         check("memwait_state", {31'd0, dut.state}, 32'd1);
      end
      hz.MemAck = 1'b1;
      step("memack", NONE);
      check("memack_state", {31'd0, dut.state}, 32'd0);
      counters("memwait", 16'd4, 16'd0);
      idle();

      // Branch overrides load-use
      hz.PCSrcE = 1'b1; hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd4; hz.Rs1D = 5'd4;
      step("branch_lw", BRFL);
      counters("branch_lw", 16'd4, 16'd1);
      idle();

      // Branch held during memstall flushes only after ack
      hz.PCSrcE = 1'b1; hz.MemReqM = 1'b1;
      step("branch_mem1", MEMST);
      step("branch_mem2", MEMST);
      hz.MemAck = 1'b1;
      step("branch_after_ack", BRFL);
      counters("branch_mem", 16'd6, 16'd2);
      idle();

      // Clear wins over a concurrent stall increment
      hz.CntClr = 1'b1; hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd2; hz.Rs1D = 5'd2;
      step("clr_lw", LWST);
      counters("clr", 16'd0, 16'd0);
      idle();

      // Saturation
      hz.MemReqM = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      counters("saturate", 16'hFFFF, 16'd0);
      hz.CntClr = 1'b1;
      step("sat_clr", MEMST);
      counters("sat_clr", 16'd0, 16'd0);
      hz.CntClr = 1'b0; hz.MemAck = 1'b1;
      step("sat_ack", NONE);
      idle();

      // Async reset in the middle of a memory wait
      hz.MemReqM = 1'b1;
      step("pre_rst_wait", MEMST);
      check("pre_rst_state", {31'd0, dut.state}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_outputs", {21'd0, outs()}, 32'd0);
      counters("async_rst", 16'd0, 16'd0);
      check("async_rst_state", {31'd0, dut.state}, 32'd0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_state", {31'd0, dut.state}, 32'd0);
      step("post_rst_idle", NONE);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
